// File: rtl/shift_sched.sv
// Two-requester log shifter: round-robin accept in IDLE, four one-bit-stage edges, result held in DONE.
// Result valid 4 cycles after accept; out_ready low stalls in DONE and keeps both request ports not-ready.
module shift_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rq0_valid,
  output logic        rq0_ready,
  input  logic [15:0] rq0_data,
  input  logic [3:0]  rq0_amt,
  input  logic [1:0]  rq0_mode,
  input  logic        rq1_valid,
  output logic        rq1_ready,
  input  logic [15:0] rq1_data,
  input  logic [3:0]  rq1_amt,
  input  logic [1:0]  rq1_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_id,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  amt;
    logic [1:0]  mode;
  } req_t;

  state_t      state;
  logic [1:0]  stage_cnt;
  logic        last_grant;
  req_t        cur;
  logic        id_q;
  logic        acc0;
  logic        acc1;

  // One log stage: shift by 2^k according to mode.
  function automatic logic [15:0] stage_fn(input logic [15:0] v, input logic [1:0] mode,
                                           input logic [1:0] k);
    logic [4:0]  sh;
    logic [15:0] r;
    sh = 5'd1 << k;
    r  = v;
    case (mode)
      2'b00:   r = v << sh;
      2'b01:   r = $signed(v) >>> sh;
      2'b10:   r = (v >> sh) | (v << (5'd16 - sh));
      default: r = v;
    endcase
    return r;
  endfunction

  // Readies are gated by rst_n so they read 0 during reset regardless of the inputs.
  assign rq0_ready = rst_n & (state == IDLE) & rq0_valid & (~rq1_valid | last_grant);
  assign rq1_ready = rst_n & (state == IDLE) & rq1_valid & (~rq0_valid | ~last_grant);
  assign acc0      = rq0_valid & rq0_ready;
  assign acc1      = rq1_valid & rq1_ready;

  assign out_valid = (state == DONE);
  assign out_data  = cur.data;
  assign out_id    = id_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      stage_cnt  <= 2'd0;
      last_grant <= 1'b1;
      cur        <= '0;
      id_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (acc0) begin
            cur        <= '{data: rq0_data, amt: rq0_amt, mode: rq0_mode};
            id_q       <= 1'b0;
            last_grant <= 1'b0;
            stage_cnt  <= 2'd0;
            state      <= SHIFT;
          end else if (acc1) begin
            cur        <= '{data: rq1_data, amt: rq1_amt, mode: rq1_mode};
            id_q       <= 1'b1;
            last_grant <= 1'b1;
            stage_cnt  <= 2'd0;
            state      <= SHIFT;
          end
        end
        SHIFT: begin
          if (cur.amt[stage_cnt])
            cur.data <= stage_fn(cur.data, cur.mode, stage_cnt);
          stage_cnt <= stage_cnt + 2'd1;
          if (stage_cnt == 2'd3)
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 clk  input  1  — the block's only clock; all state updates on the rising edge.
REQ-002 rst_n  input  1  — reset, asynchronous and active-low.
REQ-003 rq0_valid  input  1  — requester 0 has a shift request pending.
REQ-004 rq0_ready  output  1  — requester 0's request is accepted this cycle.
REQ-005 rq0_data  input  16  — operand from requester 0.
REQ-006 rq0_amt  input  4  — shift amount from requester 0, range 0..15.
REQ-007 rq0_mode  input  2  — operation from requester 0: 00 SLL, 01 SRA, 10 ROR, 11 pass-through.
REQ-008 rq1_valid, rq1_ready, rq1_data, rq1_amt, rq1_mode  — requester 1 port; same directions, widths and meanings as REQ-003..REQ-007.
REQ-009 out_valid  output  1  — result available.
REQ-010 out_ready  input  1  — consumer accepts the result.
REQ-011 out_data  output  16  — shifted result.
REQ-012 out_id  output  1  — index of the requester that owns out_data.
REQ-013 busy  output  1  — high whenever the state is not IDLE.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE.
REQ-015 A 2-bit stage counter is used in SHIFT.
REQ-016 A last_grant flop is kept, reset value 1.
REQ-017 In IDLE only, rqN_ready is driven combinationally as follows:
  - rq0_ready = rq0_valid & (~rq1_valid | last_grant==1).
  - rq1_ready = rq1_valid & (~rq0_valid | last_grant==0).
  - Both ready signals are 0 in every state other than IDLE.
REQ-018 A request is accepted at the edge where rqN_valid & rqN_ready. That edge:
  - latches data, amt, mode and id N;
  - sets last_grant=N;
  - clears the stage counter;
  - moves the FSM to SHIFT.
REQ-019 In SHIFT, one log stage is applied per edge for stage k = 0,1,2,3. If amt[k]=1 the working value is shifted by 2^k:
  - SLL: shift left, zero fill.
  - SRA: shift right, fill with bit 15.
  - ROR: rotate right.
  - 11 (pass-through): value unchanged.
REQ-020 After stage 3 the FSM moves to DONE. Latency is fixed: out_valid is first high 4 cycles after the accept edge, independent of amt, including amt=0.
REQ-021 In DONE, out_valid=1, and out_data and out_id hold stable until the edge where out_ready=1. That edge moves the FSM to IDLE.
REQ-022 A new request cannot be accepted in the same cycle as a DONE→IDLE transition. Minimum spacing between accepts is therefore 6 cycles.
REQ-023 rqN_valid deasserted while rqN_ready=0 (not yet accepted) is legal; nothing is latched.
REQ-024 rqN_* input changes during SHIFT or DONE do not affect the operation in flight.
REQ-025 out_valid is high only in DONE.
REQ-026 busy = (state != IDLE).

Reset
REQ-027 While rst_n=0, immediately and independent of clk:
  - state = IDLE, stage counter = 0, last_grant = 1;
  - out_valid = 0, out_data = 0x0000, out_id = 0, busy = 0;
  - rq0_ready = rq1_ready = 0.
REQ-028 Reset asserted during SHIFT or DONE aborts the operation; no result is ever presented for it.
REQ-029 After rst_n deasserts, the first cycle is IDLE and may accept a request.

Verification
REQ-030 SLL: rq0 data=0x0001, amt=4, mode=00 → out_valid 4 cycles after accept; out_data=0x0010, out_id=0.
REQ-031 SRA/ROR:
  - rq1 data=0x8000, amt=15, mode=01 → out_data=0xFFFF, out_id=1.
  - data=0x0001, amt=1, mode=10 → out_data=0x8000.
  - data=0x1234, amt=0, mode=00 → out_data=0x1234 after 4 cycles.
REQ-032 Arbitration:
  - rq0 and rq1 both valid after reset → rq0 served first, then rq1.
  - Both held valid continuously → grants alternate 0,1,0,1.
  - Only rq1 valid repeatedly → rq1 served every time.
REQ-033 Backpressure: out_ready held 0 for 10 cycles in DONE → out_valid stays 1 and out_data/out_id stay stable; rqN_ready stays 0. Once out_ready=1, out_valid drops the next cycle.
REQ-034 Reset mid-operation: rst_n pulsed low during stage 2 of SHIFT → outputs take the REQ-027 values immediately; no out_valid follows. The next request after reset completes normally.
REQ-035 Ready timing: a request presented during SHIFT or DONE sees rqN_ready=0. It is accepted in the first IDLE cycle.
